// File: rtl/mac3_pkg.sv
// Shared constants and types for the three-tap multiply-accumulate pipeline.
package mac3_pkg;
    localparam int DATA_W  = 32;
    localparam int RUN_LEN = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [1:0]        run_cnt_t;

    localparam run_cnt_t RUN_CNT_MAX  = run_cnt_t'(RUN_LEN);
    localparam run_cnt_t RUN_CNT_FULL = run_cnt_t'(RUN_LEN - 1);
endpackage

// File: rtl/mac3_pipe_if.sv
// Sample-in / result-out bus for mac3_pipe.
interface mac3_if #(parameter int DATA_W = mac3_pkg::DATA_W);
    // validi qualifies data_in on every rising edge; there is no ready, the block
    // never stalls. valido marks data_out as a result; data_out is zero otherwise.
    logic              validi;
    logic [DATA_W-1:0] data_in;
    logic              valido;
    logic [DATA_W-1:0] data_out;

    modport master (output validi, data_in, input valido, data_out);
    modport slave  (input validi, data_in, output valido, data_out);
endinterface

// File: rtl/mac3_window.sv
// Run counter and two-deep sample history; window_full_o flags a third consecutive sample.
module mac3_window #(
    parameter int DATA_W = mac3_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              validi_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] h0_o,
    output logic [DATA_W-1:0] h1_o,
    output logic              window_full_o
);
    import mac3_pkg::*;

    run_cnt_t          cnt_q, cnt_d;
    logic [DATA_W-1:0] h0_q, h0_d;
    logic [DATA_W-1:0] h1_q, h1_d;

    always_comb begin
        cnt_d = cnt_q;
        h0_d  = h0_q;
        h1_d  = h1_q;
        if (validi_i) begin
            cnt_d = (cnt_q == RUN_CNT_MAX) ? cnt_q : cnt_q + 2'd1;
            h0_d  = data_i;
            h1_d  = h0_q;
        end else begin
            // A gap breaks the run; history is stale but is never used until refilled.
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            cnt_q <= '0;
            h0_q  <= '0;
            h1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            h0_q  <= h0_d;
            h1_q  <= h1_d;
        end
    end

    assign h0_o          = h0_q;
    assign h1_o          = h1_q;
    assign window_full_o = validi_i && (cnt_q >= RUN_CNT_FULL);
endmodule

// File: rtl/mac3_pipe.sv
// Sliding three-sample MAC: data_out = h1*h0 + data_in once three samples are in a row.
// Define MAC3_SAT_EN to saturate to all-ones instead of wrapping modulo 2^DATA_W.
module mac3_pipe #(
    parameter int DATA_W = mac3_pkg::DATA_W
) (
    input  logic clk,
    input  logic rst_,
    mac3_if.slave bus
);
    import mac3_pkg::*;

    logic [DATA_W-1:0] h0, h1;
    logic              window_full;
    logic [DATA_W-1:0] result;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    mac3_window #(.DATA_W(DATA_W)) u_window (
        .clk           (clk),
        .rst_          (rst_),
        .validi_i      (bus.validi),
        .data_i        (bus.data_in),
        .h0_o          (h0),
        .h1_o          (h1),
        .window_full_o (window_full)
    );

`ifdef MAC3_SAT_EN
    logic [2*DATA_W:0] exact;
    assign exact  = (2*DATA_W+1)'(h1) * (2*DATA_W+1)'(h0) + (2*DATA_W+1)'(bus.data_in);
    assign result = (|exact[2*DATA_W:DATA_W]) ? '1 : exact[DATA_W-1:0];
`else
    assign result = h1 * h0 + bus.data_in;
`endif

    always_comb begin
        valid_d = window_full;
        data_d  = window_full ? result : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.valido   = valid_q;
    assign bus.data_out = data_q;
endmodule

// File: tb/tb_mac3_pipe.sv
// Directed bench for mac3_pipe: per-step literal expectations plus a run-queue model checked every cycle.
module tb_mac3_pipe;
    import mac3_pkg::*;

    logic clk;
    logic rst_;
    int   checks;
    int   failures;

    mac3_if #(.DATA_W(DATA_W)) bus ();

    mac3_pipe #(.DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst_       = 1'b0;
        bus.validi = 1'b0;
        bus.data_in = '0;
    end

    // scoreboard: model keeps the samples of the current run, newest last
    data_t run_q[$];
    logic  exp_v_q[$];
    data_t exp_q[$];

    function automatic data_t model_result(data_t a, data_t b, data_t c);
        logic [2*DATA_W:0] full;
        full = {{(DATA_W+1){1'b0}}, a} * {{(DATA_W+1){1'b0}}, b} + {{(DATA_W+1){1'b0}}, c};
`ifdef MAC3_SAT_EN
        if (full > {{(DATA_W+1){1'b0}}, {DATA_W{1'b1}}}) return '1;
`endif
        return full[DATA_W-1:0];
    endfunction

    always @(posedge clk) begin
        logic  ev;
        data_t ed;
        logic  av;
        data_t ad;
        ev = 1'b0;
        ed = '0;
        if (!rst_) begin
            run_q.delete();
        end else if (bus.validi) begin
            run_q.push_back(bus.data_in);
            if (run_q.size() > RUN_LEN) void'(run_q.pop_front());
            if (run_q.size() == RUN_LEN) begin
                ev = 1'b1;
                ed = model_result(run_q[0], run_q[1], run_q[2]);
            end
        end else begin
            run_q.delete();
        end
        exp_v_q.push_back(ev);
        exp_q.push_back(ed);
        #1;
        ev = exp_v_q.pop_front();
        ed = exp_q.pop_front();
        av = bus.valido;
        ad = bus.data_out;
        checks++;
        if (av !== ev || ad !== ed) begin
            failures++;
            $display("FAIL model t=%0t valido=%b data_out=%h expected valido=%b data_out=%h",
                     $time, av, ad, ev, ed);
        end
    end

    // driver: apply one edge worth of inputs and check a hand-computed result
    task automatic drive(input logic r, input logic v, input data_t d,
                         input logic ev, input data_t ed, input string name);
        @(negedge clk);
        rst_        = r;
        bus.validi  = v;
        bus.data_in = d;
        @(posedge clk);
        #2;
        checks++;
        if (bus.valido !== ev || bus.data_out !== ed) begin
            failures++;
            $display("FAIL %s valido=%b data_out=%h expected valido=%b data_out=%h",
                     name, bus.valido, bus.data_out, ev, ed);
        end
    endtask

    localparam data_t OVF_EXP =
`ifdef MAC3_SAT_EN
        32'hFFFF_FFFF;
`else
        32'h0000_0001;
`endif

    initial begin
        checks   = 0;
        failures = 0;

        // reset held with live input
        drive(1'b0, 1'b1, 32'd5, 1'b0, 32'd0, "reset_hold0");
        drive(1'b0, 1'b1, 32'd5, 1'b0, 32'd0, "reset_hold1");
        drive(1'b1, 1'b1, 32'd5, 1'b0, 32'd0, "post_reset1");
        drive(1'b1, 1'b1, 32'd5, 1'b0, 32'd0, "post_reset2");
        drive(1'b1, 1'b1, 32'd5, 1'b1, 32'd30, "post_reset3");
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "post_reset_gap");

        // basic run of three
        drive(1'b1, 1'b1, 32'd2, 1'b0, 32'd0, "basic1");
        drive(1'b1, 1'b1, 32'd3, 1'b0, 32'd0, "basic2");
        drive(1'b1, 1'b1, 32'd4, 1'b1, 32'd10, "basic3");
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "basic_drop");
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "basic_idle");

        // short runs never produce
        drive(1'b1, 1'b1, 32'd7, 1'b0, 32'd0, "short1");
        drive(1'b1, 1'b1, 32'd8, 1'b0, 32'd0, "short2");
        drive(1'b1, 1'b0, 32'd9, 1'b0, 32'd0, "short3");
        drive(1'b1, 1'b1, 32'd6, 1'b0, 32'd0, "short4");
        drive(1'b1, 1'b1, 32'd5, 1'b0, 32'd0, "short5");
        drive(1'b1, 1'b0, 32'd4, 1'b0, 32'd0, "short6");
        drive(1'b1, 1'b1, 32'd3, 1'b0, 32'd0, "short7");
        drive(1'b1, 1'b0, 32'd2, 1'b0, 32'd0, "short8");

        // streaming sliding window
        drive(1'b1, 1'b1, 32'd2, 1'b0, 32'd0, "stream1");
        drive(1'b1, 1'b1, 32'd3, 1'b0, 32'd0, "stream2");
        drive(1'b1, 1'b1, 32'd4, 1'b1, 32'd10, "stream3");
        drive(1'b1, 1'b1, 32'd5, 1'b1, 32'd17, "stream4");
        drive(1'b1, 1'b1, 32'd6, 1'b1, 32'd26, "stream5");
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "stream_drop");

        // overflow boundary
        drive(1'b1, 1'b1, 32'h0001_0000, 1'b0, 32'd0, "ovf1");
        drive(1'b1, 1'b1, 32'h0001_0000, 1'b0, 32'd0, "ovf2");
        drive(1'b1, 1'b1, 32'h0000_0001, 1'b1, OVF_EXP, "ovf3");
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "ovf_drop");

        // largest operands, no gap between runs after a single-cycle drop
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, "max1");
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, "max2");
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1,
              model_result(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), "max3");
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "max_drop");

        // mid-run reset discards partial history
        drive(1'b1, 1'b1, 32'd1, 1'b0, 32'd0, "midrst1");
        drive(1'b1, 1'b1, 32'd2, 1'b0, 32'd0, "midrst2");
        drive(1'b0, 1'b1, 32'd9, 1'b0, 32'd0, "midrst_reset");
        drive(1'b1, 1'b1, 32'd3, 1'b0, 32'd0, "midrst3");
        drive(1'b1, 1'b1, 32'd4, 1'b0, 32'd0, "midrst4");
        drive(1'b1, 1'b1, 32'd5, 1'b1, 32'd17, "midrst5");
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "midrst_drop");

        // reset asserted on an edge that would otherwise produce a result
        drive(1'b1, 1'b1, 32'd2, 1'b0, 32'd0, "rstprio1");
        drive(1'b1, 1'b1, 32'd2, 1'b0, 32'd0, "rstprio2");
        drive(1'b0, 1'b1, 32'd2, 1'b0, 32'd0, "rstprio3");
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "rstprio_idle");

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
